// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache for the memory stage.
// Hits complete combinationally; misses stall via dhit while a dirty victim is written back and the line is refilled.
module dcache_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LoadM,
  input  logic              MemWriteM,
  input  logic              ByteM,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              dhit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned TAG_W  = ADDR_W - 4 - INDEX_W;
  localparam int unsigned LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]   valid_q;
  logic [LINES-1:0]   dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINE_W-1:0]  data_q [LINES];
  logic [TAG_W-1:0]   vic_tag_q, vic_tag_d;
  logic [INDEX_W-1:0] vic_idx_q, vic_idx_d;

  logic [3:0]         off;
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               access;
  logic               line_hit;
  logic [LINE_W-1:0]  cur_line;
  logic [LINE_W-1:0]  st_line;
  logic [7:0]         rd_byte;
  logic [31:0]        rd_word;
  logic [31:0]        rd_val;

  logic               hit_wr;
  logic               wb_done;
  logic               fill;
  logic               dhit_c;
  logic               mem_req_c;
  logic               mem_we_c;
  logic [ADDR_W-1:0]  mem_addr_c;
  logic [31:0]        rdata_c;

  // Address split and lookup of the indexed line
  assign off      = addr[3:0];
  assign req_idx  = addr[3+INDEX_W:4];
  assign req_tag  = addr[ADDR_W-1:4+INDEX_W];
  assign access   = LoadM | MemWriteM;
  assign cur_line = data_q[req_idx];
  assign line_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign rd_byte  = cur_line[{off, 3'd0} +: 8];
  assign rd_word  = cur_line[{off[3:2], 5'd0} +: 32];
  assign rd_val   = ByteM ? {{24{rd_byte[7]}}, rd_byte} : rd_word;

  // Store data merged into the current line
  always_comb begin
    st_line = cur_line;
    if (ByteM) begin
      st_line[{off, 3'd0} +: 8] = wdata[7:0];
    end else begin
      st_line[{off[3:2], 5'd0} +: 32] = wdata;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    vic_tag_d  = vic_tag_q;
    vic_idx_d  = vic_idx_q;
    hit_wr     = 1'b0;
    wb_done    = 1'b0;
    fill       = 1'b0;
    dhit_c     = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    mem_addr_c = '0;
    rdata_c    = '0;

    case (state_q)
      IDLE: begin
        if (!access) begin
          dhit_c = 1'b1;
        end else if (line_hit) begin
          dhit_c = 1'b1;
          if (MemWriteM) begin
            hit_wr = 1'b1;
          end else begin
            rdata_c = rd_val;
          end
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d   = WB;
          vic_tag_d = tag_q[req_idx];
          vic_idx_d = req_idx;
        end else begin
          state_d = REFILL;
        end
      end
      WB: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        mem_addr_c = {vic_tag_q, vic_idx_q, 4'b0000};
        if (mem_ready) begin
          wb_done = 1'b1;
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {req_tag, req_idx, 4'b0000};
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset forces everything quiet, including the combinational outputs
    if (!reset) begin
      state_d   = IDLE;
      hit_wr    = 1'b0;
      wb_done   = 1'b0;
      fill      = 1'b0;
      dhit_c    = 1'b0;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      rdata_c   = '0;
    end
  end

  // State, victim capture and line status bits
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      vic_tag_q <= '0;
      vic_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      vic_tag_q <= vic_tag_d;
      vic_idx_q <= vic_idx_d;
      if (hit_wr) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[vic_idx_q] <= 1'b0;
      end
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (hit_wr) begin
      data_q[req_idx] <= st_line;
    end
    if (fill) begin
      data_q[req_idx] <= mem_rdata;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign dhit      = dhit_c;
  assign rdata     = rdata_c;
  assign mem_req   = mem_req_c;
  assign mem_we    = mem_we_c;
  assign mem_addr  = mem_addr_c;
  assign mem_wdata = data_q[vic_idx_q];

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat byte-level memory view predicts load data,
// a per-index residency model predicts hits, write-backs and refills.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         LoadM, MemWriteM, ByteM;
  logic [31:0]  addr, wdata, rdata;
  logic         dhit, mem_req, mem_we, mem_ready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  dcache_ctrl #(.ADDR_W(32), .INDEX_W(2)) dut (
    .clk(clk), .reset(reset), .LoadM(LoadM), .MemWriteM(MemWriteM), .ByteM(ByteM),
    .addr(addr), .wdata(wdata), .rdata(rdata), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct { bit hit; bit chk_rd; logic [31:0] rd; } op_exp_t;
  typedef struct { bit we; logic [31:0] a; logic [127:0] d; } mem_exp_t;

  op_exp_t  op_q[$];
  mem_exp_t mem_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int fix_lat = 3;
  logic [31:0]  last_rd;
  logic [31:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  // Coherent memory view, main memory contents, and cache residency per index
  logic [127:0] arch [logic [31:0]];
  logic [127:0] memm [logic [31:0]];
  bit           rv  [4];
  bit           rdt [4];
  logic [25:0]  rt  [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] init_line(input logic [31:0] a);
    return {a ^ 32'hA5A50F0F, ~a, a * 32'd3 + 32'h80, {a[15:0], a[31:16]}};
  endfunction

  function automatic logic [127:0] get_arch(input logic [31:0] a);
    return arch.exists(a) ? arch[a] : init_line(a);
  endfunction

  function automatic logic [127:0] get_mem(input logic [31:0] a);
    return memm.exists(a) ? memm[a] : init_line(a);
  endfunction

  // Predict one access and queue its expected CPU response and memory traffic
  task automatic model_push(input bit ld, input bit st, input bit by, input logic [31:0] a,
                            input logic [31:0] wd);
    logic [31:0]  la;
    logic [31:0]  va;
    logic [127:0] ln;
    int           idx;
    bit           hit;
    op_exp_t      e;
    la  = {a[31:4], 4'h0};
    idx = int'(a[5:4]);
    hit = rv[idx] && (rt[idx] == a[31:6]);
    if (!hit) begin
      if (rv[idx] && rdt[idx]) begin
        va = {rt[idx], a[5:4], 4'h0};
        mem_q.push_back('{1'b1, va, get_arch(va)});
      end
      mem_q.push_back('{1'b0, la, 128'h0});
      rv[idx]  = 1'b1;
      rt[idx]  = a[31:6];
      rdt[idx] = 1'b0;
    end
    ln       = get_arch(la);
    e.hit    = hit;
    e.chk_rd = !(ld && st);
    e.rd     = 32'h0;
    if (st) begin
      if (by) ln[8*int'(a[3:0]) +: 8] = wd[7:0];
      else    ln[32*int'(a[3:2]) +: 32] = wd;
      arch[la] = ln;
      rdt[idx] = 1'b1;
    end else if (ld) begin
      e.rd = by ? 32'($signed(ln[8*int'(a[3:0]) +: 8])) : ln[32*int'(a[3:2]) +: 32];
    end
    op_q.push_back(e);
  endtask

  task automatic do_op(input bit ld, input bit st, input bit by, input logic [31:0] a,
                       input logic [31:0] wd, output int cyc);
    model_push(ld, st, by, a, wd);
    LoadM = ld; MemWriteM = st; ByteM = by; addr = a; wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!dhit && cyc < 100);
    if (!dhit) chk("op_complete", 128'(dhit), 128'(1));
    @(posedge clk); #1;
    LoadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
  endtask

  // CPU-side monitor
  initial begin
    bit      first;
    op_exp_t e;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) begin
        first = 1'b1;
      end else if (!(LoadM || MemWriteM)) begin
        chk("idle_dhit", 128'(dhit), 128'(1));
        chk("idle_rdata", 128'(rdata), 128'(0));
        chk("idle_mem_req", 128'(mem_req), 128'(0));
      end else if (op_q.size() != 0) begin
        if (first) begin
          chk("hit_latency", 128'(dhit), 128'(op_q[0].hit));
          first = 1'b0;
        end
        if (dhit) begin
          e = op_q.pop_front();
          if (e.chk_rd) chk("rdata", 128'(rdata), 128'(e.rd));
          last_rd = rdata;
          first   = 1'b1;
        end else if (op_q[0].chk_rd) begin
          chk("stall_rdata", 128'(rdata), 128'(0));
        end
      end
    end
  end

  // Main-memory responder and request checker
  initial begin
    mem_exp_t     e;
    logic [31:0]  ra;
    logic         rwe;
    logic [127:0] rwd;
    int           lat;
    bit           ab;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (reset && mem_req) begin
        ra = mem_addr; rwe = mem_we; rwd = mem_wdata;
        if (mem_q.size() == 0) begin
          chk("mem_unexpected_req", 128'(mem_q.size()), 128'(1));
        end else begin
          e = mem_q.pop_front();
          chk("mem_we", 128'(rwe), 128'(e.we));
          chk("mem_addr", 128'(ra), 128'(e.a));
          if (e.we) chk("mem_wdata", rwd, e.d);
        end
        lat = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
        ab  = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk);
          if (!reset) begin
            ab = 1'b1;
            break;
          end
          chk("mem_stable", {mem_wdata, 1'b0, mem_req, mem_we, mem_addr} & {rwe ? {128{1'b1}} : 128'h0, 35'h7FFFFFFFF},
              {rwd, 1'b0, 1'b1, rwe, ra} & {rwe ? {128{1'b1}} : 128'h0, 35'h7FFFFFFFF});
        end
        if (!ab) begin
          if (rwe) begin
            memm[ra]     = rwd;
            last_wb_addr = ra;
            last_wb_data = rwd;
            mem_rdata    = {4{$urandom}};
          end else begin
            mem_rdata = get_mem(ra);
          end
          mem_ready = 1'b1;
        end
      end else if (reset && $urandom_range(0, 7) == 0) begin
        mem_rdata = {4{$urandom}};
        mem_ready = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int cyc;
    int r;
    reset = 1'b0; LoadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0; addr = '0; wdata = '0;
    memm[32'h40] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_8899AABB;
    arch[32'h40] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_8899AABB;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dhit", 128'(dhit), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed sequence with 3-cycle memory latency
    do_op(1, 0, 0, 32'h40, 0, cyc);
    chk("cold_lw40_cycles", 128'(cyc), 128'(6));
    chk("cold_lw40_rdata", 128'(last_rd), 128'(32'h8899AABB));
    do_op(1, 0, 1, 32'h43, 0, cyc);
    chk("lb43_cycles", 128'(cyc), 128'(1));
    chk("lb43_rdata", 128'(last_rd), 128'(32'hFFFFFF88));
    do_op(1, 0, 1, 32'h40, 0, cyc);
    chk("lb40_rdata", 128'(last_rd), 128'(32'hFFFFFFBB));
    do_op(0, 1, 1, 32'h41, 32'h5A, cyc);
    chk("sb41_cycles", 128'(cyc), 128'(1));
    do_op(1, 0, 0, 32'h40, 0, cyc);
    chk("lw40_merged", 128'(last_rd), 128'(32'h88995ABB));
    repeat (2) @(posedge clk);
    #1;
    do_op(1, 0, 0, 32'h80, 0, cyc);
    chk("lw80_wb_cycles", 128'(cyc), 128'(10));
    chk("lw80_wb_addr", 128'(last_wb_addr), 128'(32'h40));
    chk("lw80_wb_word0", 128'(last_wb_data[31:0]), 128'(32'h88995ABB));
    do_op(0, 1, 0, 32'h94, 32'h12345678, cyc);
    chk("sw94_cycles", 128'(cyc), 128'(6));
    do_op(1, 0, 0, 32'h94, 0, cyc);
    chk("lw94_rdata", 128'(last_rd), 128'(32'h12345678));
    do_op(1, 0, 0, 32'hD4, 0, cyc);
    chk("lwd4_wb_addr", 128'(last_wb_addr), 128'(32'h90));
    chk("lwd4_wb_word1", 128'(last_wb_data[63:32]), 128'(32'h12345678));
    do_op(1, 0, 0, 32'h40, 0, cyc);
    chk("lw40_again", 128'(last_rd), 128'(32'h88995ABB));

    // Reset in the middle of a refill
    fix_lat = 20;
    model_push(1, 0, 0, 32'hC0, 0);
    LoadM = 1'b1; addr = 32'hC0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_req && cyc < 10);
    chk("refill_started", 128'(mem_req), 128'(1));
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_req", 128'(mem_req), 128'(0));
    chk("midrst_dhit", 128'(dhit), 128'(0));
    chk("midrst_rdata", 128'(rdata), 128'(0));
    op_q.delete();
    mem_q.delete();
    for (int i = 0; i < 4; i++) begin
      rv[i] = 1'b0; rdt[i] = 1'b0;
    end
    arch = memm;
    @(posedge clk); #1;
    LoadM = 1'b0;
    reset = 1'b1;
    fix_lat = 3;
    @(posedge clk); #1;
    do_op(1, 0, 0, 32'h40, 0, cyc);
    chk("postrst_lw40_cycles", 128'(cyc), 128'(6));
    chk("postrst_lw40_rdata", 128'(last_rd), 128'(32'h88995ABB));

    // Randomized traffic with random memory latency
    fix_lat = -1;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      do_op(r < 5 || r == 9, r >= 5, 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, cyc);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(posedge clk);
    chk("op_q_drained", 128'(op_q.size()), 128'(0));
    chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
